// File: rtl/arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Holds the FSM states, the requester owner codes and the fairness-counter width.
package arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BUSY_IF,
        BUSY_D,
        RESP_IF,
        RESP_D
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between the fetch port and the load/store port.
// Data has priority; a saturating streak counter guarantees fetch a slot after MAX_DATA_STREAK data grants.
module memory_arbiter
    import arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_ready,
    output logic [DATA_WIDTH-1:0]   if_rdata,

    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wstrb,
    output logic                    d_ready,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    state_t              state, next_state;
    logic [STREAK_W-1:0] streak, next_streak;
    logic                grant;
    logic                owner;

    // Fairness picker: data wins unless a waiting fetch has already watched STREAK_MAX data grants.
    always_comb begin
        grant = if_req || d_req;
        owner = (d_req && !(if_req && streak >= STREAK_MAX)) ? OWNER_D : OWNER_IF;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        next_state  = state;
        next_streak = streak;
        mem_req     = 1'b0;
        if_ready    = 1'b0;
        d_ready     = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant) begin
                    if (owner == OWNER_D) begin
                        next_state = BUSY_D;
                        if (!if_req)
                            next_streak = '0;
                        else if (streak >= STREAK_MAX)
                            next_streak = STREAK_MAX;
                        else
                            next_streak = streak + STREAK_W'(1);
                    end else begin
                        next_state  = BUSY_IF;
                        next_streak = '0;
                    end
                end
            end
            BUSY_IF: begin
                mem_req = 1'b1;
                if (mem_ack) next_state = RESP_IF;
            end
            BUSY_D: begin
                mem_req = 1'b1;
                if (mem_ack) next_state = RESP_D;
            end
            // The response cycle is a deliberate bubble so a still-high req is not re-granted.
            RESP_IF: begin
                if_ready   = 1'b1;
                next_state = IDLE;
            end
            RESP_D: begin
                d_ready    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            streak <= '0;
        end else begin
            state  <= next_state;
            streak <= next_streak;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (state == IDLE && grant) begin
                if (owner == OWNER_D) begin
                    mem_we    <= d_we;
                    mem_addr  <= d_addr;
                    mem_wdata <= d_wdata;
                    mem_wstrb <= d_wstrb;
                end else begin
                    mem_we    <= 1'b0;
                    mem_addr  <= if_addr;
                    mem_wdata <= '0;
                    mem_wstrb <= '0;
                end
            end
            if (state == BUSY_IF && mem_ack)
                if_rdata <= mem_rdata;
            if (state == BUSY_D && mem_ack && !mem_we)
                d_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level reference model.
module tb_memory_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int MAX = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [SW-1:0] d_wstrb = '0;
    logic          d_ready;
    logic [DW-1:0] d_rdata;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    memory_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_DATA_STREAK(MAX)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: one access in flight at most, described as owner/transaction, checked at negedge.
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } txn_t;

    int            m_busy = -1;   // owner of the access awaiting ack: 0 fetch, 1 data, -1 none
    int            m_resp = -1;   // owner whose ready is due this cycle
    int            m_run  = 0;    // consecutive data grants seen while fetch waited
    txn_t          m_txn  = '0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_d_rdata  = '0;

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check("rst_mem_req", mem_req, 0);
            check("rst_if_ready", if_ready, 0);
            check("rst_d_ready", d_ready, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_d_rdata", d_rdata, 0);
            check("rst_mem_fields", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 0);
            m_busy = -1; m_resp = -1; m_run = 0; m_txn = '0;
            m_if_rdata = '0; m_d_rdata = '0;
        end else begin
            check("model_mem_req", mem_req, m_busy >= 0);
            check("model_if_ready", if_ready, m_resp == 0);
            check("model_d_ready", d_ready, m_resp == 1);
            check("model_if_rdata", if_rdata, m_if_rdata);
            check("model_d_rdata", d_rdata, m_d_rdata);
            if (m_busy >= 0) begin
                check("model_mem_we", mem_we, m_txn.we);
                check("model_mem_addr", mem_addr, m_txn.addr);
                check("model_mem_wstrb", mem_wstrb, m_txn.wstrb);
                if (m_txn.we) check("model_mem_wdata", mem_wdata, m_txn.wdata);
            end
            if (m_resp >= 0) begin
                m_resp = -1;
            end else if (m_busy >= 0) begin
                if (mem_ack) begin
                    if (m_busy == 0) m_if_rdata = mem_rdata;
                    else if (!m_txn.we) m_d_rdata = mem_rdata;
                    m_resp = m_busy;
                    m_busy = -1;
                end
            end else if (d_req && (!if_req || m_run < MAX)) begin
                m_busy = 1;
                m_txn  = '{d_we, d_addr, d_wdata, d_wstrb};
                m_run  = if_req ? ((m_run < MAX) ? m_run + 1 : MAX) : 0;
            end else if (if_req) begin
                m_busy = 0;
                m_txn  = '{1'b0, if_addr, '0, '0};
                m_run  = 0;
            end
        end
    end

    // Memory responder settings; lat < 0 picks a random latency per access.
    int            lat      = 1;
    int            cur_lat  = 0;
    int            req_age  = 0;
    bit            spurious = 1'b0;
    logic [DW-1:0] ack_data = '0;
    logic [AW-1:0] grant_addr[$];

    task automatic tick();
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (req_age == 0) begin
                grant_addr.push_back(mem_addr);
                cur_lat = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            end
            if (req_age == cur_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = (lat < 0) ? $urandom : ack_data;
            end
            req_age++;
        end else begin
            req_age = 0;
            if (spurious && $urandom_range(0, 7) == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    endtask

    task automatic wait_ready(input bit is_d, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(is_d ? d_ready : if_ready) && n < 50);
        check({name, "_ready"}, is_d ? d_ready : if_ready, 1);
    endtask

    task automatic contend(input int count, input logic [15:0] expected, input string name);
        int n = 0;
        logic [15:0] order = '0;
        while (grant_addr.size() < count && n < 400) begin
            tick();
            n++;
        end
        check({name, "_grants"}, grant_addr.size(), count);
        for (int i = 0; i < grant_addr.size() && i < count; i++)
            order = {order[14:0], grant_addr[i] == 32'h2000};
        check({name, "_order"}, order, expected);
    endtask

    initial begin
        int n;
        #1 reset = 1'b0;
        repeat (2) tick();
        check("reset_mem_req", mem_req, 0);
        check("reset_readies", {if_ready, d_ready}, 2'b00);
        check("reset_rdata", {if_rdata, d_rdata}, 64'h0);
        reset = 1'b1;
        tick();

        // Single fetch, ack one cycle after mem_req.
        lat = 1; ack_data = 32'h0050_0093;
        if_req = 1'b1; if_addr = 32'h0000_0010;
        tick();
        check("fetch_mem_req", mem_req, 1);
        check("fetch_mem_addr", mem_addr, 32'h10);
        check("fetch_mem_we", mem_we, 0);
        tick();
        check("fetch_not_yet_ready", if_ready, 0);
        tick();
        check("fetch_if_ready", if_ready, 1);
        check("fetch_if_rdata", if_rdata, 32'h0050_0093);
        check("fetch_d_ready", d_ready, 0);
        if_req = 1'b0;
        tick();
        check("fetch_ready_pulse", if_ready, 0);

        // Store with a three-cycle ack delay.
        lat = 3;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
        tick();
        n = 0;
        while (mem_req && n < 20) begin
            check("store_fields", {mem_we, mem_addr, mem_wdata, mem_wstrb},
                  {1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF});
            tick();
            n++;
        end
        check("store_busy_cycles", n, 4);
        check("store_d_ready", d_ready, 1);
        check("store_d_rdata", d_rdata, 0);
        d_req = 1'b0; d_we = 1'b0;
        tick();
        check("store_ready_pulse", d_ready, 0);

        // Continuous contention: fairness order, then leave a data access in flight.
        lat = 0; ack_data = 32'hC0FF_EE00; grant_addr.delete();
        if_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0;
        if_req = 1'b1; d_req = 1'b1;
        contend(11, 16'b111_1011_1101, "fair");
        lat = 10;
        contend(12, 16'b1111_0111_1011, "fair_more");
        tick();
        check("pre_rst_mem_req", mem_req, 1);

        // Reset mid-access: mem_req falls without a clock edge; a late ack is ignored.
        #2 reset = 1'b0;
        #1 check("rst_async_mem_req", mem_req, 0);
        if_req = 1'b0; d_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        repeat (3) begin
            tick();
            check("late_ack_readies", {if_ready, d_ready, mem_req}, 3'b000);
        end
        check("late_ack_rdata", {if_rdata, d_rdata}, 64'h0);

        // Streak restarted from zero: four data grants before fetch.
        lat = 0; grant_addr.delete();
        if_req = 1'b1; d_req = 1'b1;
        contend(5, 16'b1_1110, "post_rst");
        n = 0;
        while (!if_ready && n < 20) begin tick(); n++; end
        if_req = 1'b0; d_req = 1'b0;
        tick();

        // Back-to-back: drop req the cycle after ready, re-raise with a new address.
        lat = 1; ack_data = 32'h0000_AAAA; grant_addr.delete();
        d_req = 1'b1; d_addr = 32'h40;
        wait_ready(1'b1, "b2b_first");
        tick();
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_addr = 32'h44;
        wait_ready(1'b1, "b2b_second");
        d_req = 1'b0;
        tick();
        check("b2b_count", grant_addr.size(), 2);
        if (grant_addr.size() == 2)
            check("b2b_addrs", {grant_addr[0], grant_addr[1]}, {32'h40, 32'h44});
        check("b2b_d_rdata", d_rdata, 32'h0000_AAAA);

        // Spurious ack while idle.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) begin
            tick();
            check("spur_readies", {if_ready, d_ready, mem_req}, 3'b000);
            check("spur_rdata", {if_rdata, d_rdata}, {32'hC0FF_EE00, 32'h0000_AAAA});
        end

        // Randomized traffic with random latency and stray acks; the model checks every cycle.
        lat = -1; spurious = 1'b1; grant_addr.delete();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!if_req || if_ready) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom & ~32'h3;
            end
            if (!d_req || d_ready) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = $urandom_range(0, 1) == 1;
                d_addr  = $urandom & ~32'h3;
                d_wdata = $urandom;
                d_wstrb = SW'($urandom);
            end
        end
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
